axi4_burst_addr_gen: RTL

Per-beat AXI4 address generator for memory-mapped slaves, parametrised in address width, data width and length width. It accepts one AW/AR-style burst command (addr, len, size, burst) and emits one address per data beat with valid/ready flow control. It fully implements FIXED, INCR and WRAP, flags protocol violations with an AXI response code, and sits between a slave's address channel and its memory or register datapath.

---
 rtl/axi4_burst_addr_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 per-beat address generator: takes one AW/AR-style burst command and
// emits one address per data beat (FIXED/INCR/WRAP), with SLVERR on illegal bursts.
module axi4_burst_addr_gen #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 8,
  parameter int CHECK_4K = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LEN_W-1:0]  beat_idx,
  output logic              beat_last,
  output logic [1:0]        beat_resp
);

  localparam int         MAX_SIZE    = $clog2(DATA_W/8);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
           (len == LEN_W'(7)) || (len == LEN_W'(15));
  endfunction

  state_t            r_state, w_state_nxt;
  mode_t             r_mode, w_mode;
  logic [ADDR_W-1:0] r_addr, r_s, r_smask, r_wrap_b, r_wrap_mask;
  logic [LEN_W-1:0]  r_idx, r_len;
  logic [1:0]        r_resp;

  logic              w_cmd_fire, w_beat_fire, w_last;
  logic [ADDR_W-1:0] w_s, w_s_mask, w_len_ext, w_total, w_wrap_mask;
  logic [ADDR_W-1:0] w_start_align, w_end, w_sum, w_next;
  logic              w_size_err, w_wrap_ok, w_cross, w_err;

  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_beat_fire = beat_valid & beat_ready;
  assign w_last      = (r_idx == r_len);

  // Command decode: everything here is captured at acceptance only.
  assign w_s           = ADDR_W'(1) << cmd_size;
  assign w_s_mask      = w_s - ADDR_W'(1);
  assign w_len_ext     = ADDR_W'(cmd_len);
  assign w_total       = (w_len_ext + ADDR_W'(1)) << cmd_size;
  assign w_wrap_mask   = w_total - ADDR_W'(1);
  assign w_start_align = cmd_addr & ~w_s_mask;
  assign w_end         = w_start_align + (w_len_ext << cmd_size);
  assign w_size_err    = (cmd_size > 3'(MAX_SIZE));
  assign w_wrap_ok     = (cmd_burst == BURST_WRAP) && wrap_len_ok(cmd_len) &&
                         ((cmd_addr & w_s_mask) == '0);
  // Page compare through XOR so every bit of the end address participates.
  assign w_cross       = (CHECK_4K != 0) && (cmd_burst == BURST_INCR) &&
                         (|((w_end ^ cmd_addr) >> 12));
  assign w_err         = (cmd_burst == BURST_RSVD) ||
                         ((cmd_burst == BURST_WRAP) && !w_wrap_ok) ||
                         w_size_err || w_cross;

  always_comb begin
    w_mode = M_INCR;
    if (cmd_burst == BURST_FIXED) w_mode = M_FIXED;
    else if (w_wrap_ok)           w_mode = M_WRAP;
  end

  // The single address-path adder; aligning first makes beat 1 of an
  // unaligned INCR land on the next S boundary.
  assign w_sum = (r_addr & ~r_smask) + r_s;

  always_comb begin
    w_next = w_sum;
    case (r_mode)
      M_FIXED: w_next = r_addr;
      M_WRAP:  w_next = r_wrap_b | (w_sum & r_wrap_mask);
      default: w_next = w_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire)            w_state_nxt = BURST;
      BURST:   if (w_beat_fire && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_resp      <= RESP_OKAY;
      r_mode      <= M_INCR;
      r_s         <= '0;
      r_smask     <= '0;
      r_wrap_b    <= '0;
      r_wrap_mask <= '0;
    end else if (w_cmd_fire) begin
      r_addr      <= cmd_addr;
      r_idx       <= '0;
      r_len       <= cmd_len;
      r_resp      <= w_err ? RESP_SLVERR : RESP_OKAY;
      r_mode      <= w_mode;
      r_s         <= w_s;
      r_smask     <= w_s_mask;
      r_wrap_b    <= cmd_addr & ~w_wrap_mask;
      r_wrap_mask <= w_wrap_mask;
    end else if (w_beat_fire && !w_last) begin
      r_addr <= w_next;
      r_idx  <= r_idx + LEN_W'(1);
    end
  end

  assign cmd_ready  = (r_state == IDLE) && !rst;
  assign beat_valid = (r_state == BURST);
  assign beat_addr  = r_addr;
  assign beat_idx   = r_idx;
  assign beat_last  = beat_valid && w_last;
  assign beat_resp  = r_resp;

endmodule
